// File: rtl/conv_row_collector.sv
// conv_row_collector: gathers convolved output rows into a full feature map and offers it
// downstream with a valid/ack handshake. Optional fused ReLU on write: define CONV_RELU_EN.
module conv_row_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   row_valid,
  output logic                                   row_ready,
  input  logic [5:0]                             row_number,
  input  logic [0:(W-F+1)*DATA_WIDTH-1]          row_data,
  output logic [5:0]                             rows_done,
  output logic                                   row_err,
  output logic                                   map_valid,
  input  logic                                   map_ack,
  output logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]  out_map
);
  // state   | meaning
  // COLLECT | accepting rows, map not yet complete
  // FULL    | every output row present; map offered until map_ack

  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int ROWW = OW * DATA_WIDTH;
  localparam logic [5:0] LAST_ROW_CNT = 6'(OH - 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t          state, state_nxt;
  logic [OH-1:0]   row_mask;
  logic [0:ROWW-1] wr_row;
  logic            accept, in_range, seen, new_row;

  assign row_ready = (state == COLLECT);
  assign map_valid = (state == FULL);
  assign accept    = row_valid & row_ready;
  assign in_range  = (row_number < 6'(OH));

  // Decoded by loop so an out-of-range index never addresses the mask.
  always_comb begin
    seen = 1'b0;
    for (int r = 0; r < OH; r++)
      if (row_number == 6'(r)) seen = row_mask[r];
  end

  assign new_row = accept & in_range & ~seen;

  always_comb begin
    wr_row = row_data;
`ifdef CONV_RELU_EN
    for (int c = 0; c < OW; c++)
      if (row_data[c*DATA_WIDTH]) wr_row[c*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (new_row && (rows_done == LAST_ROW_CNT)) state_nxt = FULL;
      FULL:    if (map_ack) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      row_mask  <= '0;
      rows_done <= '0;
      row_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == FULL) && map_ack) begin
        row_mask  <= '0;
        rows_done <= '0;
      end else if (new_row) begin
        for (int r = 0; r < OH; r++)
          if (row_number == 6'(r)) row_mask[r] <= 1'b1;
        rows_done <= rows_done + 6'd1;
      end
      if (accept && !in_range) row_err <= 1'b1;
    end
  end

  // Map is not cleared between frames; each new frame overwrites row by row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_map <= '0;
    end else if (accept && in_range) begin
      for (int r = 0; r < OH; r++)
        if (row_number == 6'(r)) out_map[r*ROWW +: ROWW] <= wr_row;
    end
  end

endmodule

// File: tb/tb_conv_row_collector.sv
// Randomized self-checking bench for conv_row_collector against a set-based frame model.
module tb_conv_row_collector;
  localparam int DW   = 32;
  localparam int H    = 32;
  localparam int W    = 32;
  localparam int F    = 5;
  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int ROWW = OW * DW;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   row_valid;
  logic                   row_ready;
  logic [5:0]             row_number;
  logic [0:ROWW-1]        row_data;
  logic [5:0]             rows_done;
  logic                   row_err;
  logic                   map_valid;
  logic                   map_ack;
  logic [0:OH*ROWW-1]     out_map;

  conv_row_collector #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) dut (
    .clk(clk), .reset(reset), .row_valid(row_valid), .row_ready(row_ready),
    .row_number(row_number), .row_data(row_data), .rows_done(rows_done),
    .row_err(row_err), .map_valid(map_valid), .map_ack(map_ack), .out_map(out_map)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stored words, set of rows seen this frame, full flag, sticky error.
  logic [DW-1:0] m_map [OH][OW];
  bit            m_seen [OH];
  bit            m_full;
  bit            m_err;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef CONV_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic int nseen();
    int n = 0;
    foreach (m_seen[i]) n += int'(m_seen[i]);
    return n;
  endfunction

  task automatic model_reset();
    foreach (m_map[r, c]) m_map[r][c] = '0;
    foreach (m_seen[i]) m_seen[i] = 1'b0;
    m_full = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    int rn;
    rn = int'(row_number);
    if (!m_full) begin
      if (row_valid) begin
        if (rn < OH) begin
          for (int c = 0; c < OW; c++) m_map[rn][c] = relu(row_data[c*DW +: DW]);
          m_seen[rn] = 1'b1;
          if (nseen() == OH) m_full = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (map_ack) begin
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      m_full = 1'b0;
    end
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, "_ready"}, 64'(row_ready), 64'(!m_full));
    chk({tag, "_valid"}, 64'(map_valid), 64'(m_full));
    chk({tag, "_done"},  64'(rows_done), 64'(nseen()));
    chk({tag, "_err"},   64'(row_err),   64'(m_err));
  endtask

  task automatic check_map(input string tag);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        chk($sformatf("%s[%0d][%0d]", tag, r, c),
            64'(out_map[(r*OW + c)*DW +: DW]), 64'(m_map[r][c]));
  endtask

  task automatic cycle(input logic v, input logic [5:0] rn, input logic [0:ROWW-1] d,
                       input logic ack, input string tag);
    row_valid  = v;
    row_number = rn;
    row_data   = d;
    map_ack    = ack;
    @(posedge clk);
    model_edge();
    #1;
    check_ctrl(tag);
  endtask

  function automatic logic [0:ROWW-1] pat_row(input int r);
    logic [0:ROWW-1] d;
    for (int c = 0; c < OW; c++) d[c*DW +: DW] = DW'((r << 8) | c);
    return d;
  endfunction

  function automatic logic [0:ROWW-1] rand_row();
    logic [0:ROWW-1] d;
    for (int c = 0; c < OW; c++)
      case ($urandom_range(0, 3))
        0:       d[c*DW +: DW] = 32'h8000_0001;
        1:       d[c*DW +: DW] = 32'h7FFF_FFFF;
        default: d[c*DW +: DW] = $urandom;
      endcase
    return d;
  endfunction

  function automatic logic [0:ROWW-1] fill_row(input logic [DW-1:0] w);
    logic [0:ROWW-1] d;
    for (int c = 0; c < OW; c++) d[c*DW +: DW] = w;
    return d;
  endfunction

  int              seq[$];
  logic [0:ROWW-1] dq[$];
  int              perm[OH];

  task automatic mk_perm();
    int j, t;
    for (int i = 0; i < OH; i++) perm[i] = i;
    for (int i = OH - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  task automatic feed(input bit gaps, input string tag);
    foreach (seq[i]) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0)
          cycle(1'b0, 6'($urandom_range(0, 63)), rand_row(), 1'($urandom_range(0, 1)), {tag, "_idle"});
      cycle(1'b1, 6'(seq[i]), dq[i], 1'b0, tag);
    end
  endtask

  task automatic hold_full(input int n, input logic [0:ROWW-1] d, input string tag);
    repeat (n) cycle(1'b1, 6'd0, d, 1'b0, {tag, "_hold"});
    check_map({tag, "_held"});
    cycle(1'b0, 6'd0, '0, 1'b1, {tag, "_ack"});
    chk({tag, "_ack_ready"}, 64'(row_ready), 64'd1);
    chk({tag, "_ack_done"},  64'(rows_done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; row_valid = 1'b0; row_number = '0; row_data = '0; map_ack = 1'b0;
    model_reset();
    #2;
    chk("rst_done",  64'(rows_done), 64'd0);
    chk("rst_valid", 64'(map_valid), 64'd0);
    chk("rst_err",   64'(row_err),   64'd0);
    check_map("rst_map");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_ctrl("rst_rel");

    // Frame 1: rows in order.
    seq.delete(); dq.delete();
    for (int r = 0; r < OH; r++) begin seq.push_back(r); dq.push_back(pat_row(r)); end
    feed(1'b0, "f1");
    chk("f1_map_valid", 64'(map_valid), 64'd1);
    chk("f1_rows_done", 64'(rows_done), 64'd28);
    check_map("f1_map");
    cycle(1'b0, 6'd0, '0, 1'b1, "f1_ack");

    // Frame 2: reverse order, same data.
    seq.delete(); dq.delete();
    for (int r = OH - 1; r >= 0; r--) begin seq.push_back(r); dq.push_back(pat_row(r)); end
    feed(1'b0, "f2");
    chk("f2_map_valid", 64'(map_valid), 64'd1);
    check_map("f2_map");
    cycle(1'b0, 6'd0, '0, 1'b1, "f2_ack");

    // Frame 3: duplicate row 5 overwritten, out-of-range row 30, shuffled, with gaps.
    mk_perm();
    seq.delete(); dq.delete();
    seq.push_back(5);  dq.push_back(pat_row(5));
    seq.push_back(30); dq.push_back(pat_row(30));
    for (int i = 0; i < OH; i++) begin
      if (perm[i] == 5) continue;
      if (seq.size() == 10) begin seq.push_back(5); dq.push_back(fill_row(32'hAAAA_AAAA)); end
      seq.push_back(perm[i]); dq.push_back(pat_row(perm[i]));
    end
    feed(1'b1, "f3");
    chk("f3_row_err",   64'(row_err),   64'd1);
    chk("f3_rows_done", 64'(rows_done), 64'd28);
    chk("f3_row5",      64'(out_map[5*ROWW +: DW]), 64'(relu(32'hAAAA_AAAA)));
    check_map("f3_map");
    hold_full(3, fill_row(32'hFFFF_FFFF), "f3");

    // Frame 4: random data, order, duplicates, gaps and stray acks.
    mk_perm();
    seq.delete(); dq.delete();
    for (int i = 0; i < OH; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        seq.push_back(perm[$urandom_range(0, i - 1)]); dq.push_back(rand_row());
      end
      if ($urandom_range(0, 7) == 0) begin
        seq.push_back($urandom_range(OH, 63)); dq.push_back(rand_row());
      end
      seq.push_back(perm[i]); dq.push_back(rand_row());
    end
    feed(1'b1, "f4");
    check_map("f4_map");
    hold_full($urandom_range(1, 4), rand_row(), "f4");
    chk("f4_err_sticky", 64'(row_err), 64'd1);

    // Reset after 10 rows of a new frame.
    mk_perm();
    seq.delete(); dq.delete();
    for (int i = 0; i < 10; i++) begin seq.push_back(perm[i]); dq.push_back(rand_row()); end
    feed(1'b1, "f5");
    chk("f5_rows_done_pre", 64'(rows_done), 64'd10);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("f5_rst_done",  64'(rows_done), 64'd0);
    chk("f5_rst_valid", 64'(map_valid), 64'd0);
    chk("f5_rst_err",   64'(row_err),   64'd0);
    check_map("f5_rst_map");
    @(negedge clk);
    reset = 1'b0;

    // Frame 6: signed-boundary words in every row.
    mk_perm();
    seq.delete(); dq.delete();
    for (int i = 0; i < OH; i++) begin
      logic [0:ROWW-1] d;
      d = rand_row();
      d[0 +: DW]  = 32'h8000_0001;
      d[DW +: DW] = 32'h7FFF_FFFF;
      seq.push_back(perm[i]); dq.push_back(d);
    end
    feed(1'b1, "f6");
    chk("f6_neg", 64'(out_map[0 +: DW]),  64'(relu(32'h8000_0001)));
    chk("f6_pos", 64'(out_map[DW +: DW]), 64'h7FFF_FFFF);
    check_map("f6_map");
    cycle(1'b0, 6'd0, '0, 1'b1, "f6_ack");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
